// File: rtl/booth_mult.sv
// booth_mult: multicycle signed multiplier using radix-4 modified Booth recoding.
// Retires two multiplier bits per cycle into an arithmetic-right-shift product
// register. A start strobe in any state restarts the operation. The result and
// exception flag are held until the next completion or reset.
module booth_mult #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int N     = WIDTH / 2;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int UW    = WIDTH + 2;       // accumulator width, room for +-2M
   localparam int PW    = 2 * WIDTH + 3;   // {upper, multiplier, booth guard bit}
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [UW-1:0]    m_q, m_d;
   logic [PW-1:0]           p_q, p_d;
   logic [WIDTH-1:0]        res_q, res_d;
   logic                    exc_q, exc_d;
   logic                    rdy_q, rdy_d;

   logic [2:0]              trip;
   logic signed [UW-1:0]    upper;
   logic signed [UW-1:0]    addend;
   logic signed [UW-1:0]    sum;
   logic signed [PW-1:0]    p_acc;
   logic signed [PW-1:0]    p_step;
   logic [2*WIDTH-1:0]      product;
   logic [WIDTH:0]          prod_hi;
   logic                    ovf;

   // One Booth step: recode the low triplet, add to the upper part, shift right by two.
   always_comb begin
      trip   = p_q[2:0];
      upper  = p_q[PW-1:WIDTH+1];
      addend = '0;
      case (trip)
         3'b001, 3'b010: addend = m_q;
         3'b011:         addend = m_q <<< 1;
         3'b100:         addend = -(m_q <<< 1);
         3'b101, 3'b110: addend = -m_q;
         default:        addend = '0;
      endcase
      sum     = upper + addend;
      p_acc   = {sum, p_q[WIDTH:0]};
      p_step  = p_acc >>> 2;
      product = p_step[2*WIDTH:1];
      // The product fits in WIDTH signed bits only if its top WIDTH+1 bits agree.
      prod_hi = product[2*WIDTH-1:WIDTH-1];
      ovf     = ~((&prod_hi) | ~(|prod_hi));
   end

   // Control and datapath next state; a start strobe overrides whatever is in flight.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      p_d     = p_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
      if (ctrl_MULT) begin
         m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
         p_d     = {{UW{1'b0}}, data_operandB, 1'b0};
         cnt_d   = '0;
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               p_d   = p_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = S_DONE;
                  res_d   = product[WIDTH-1:0];
                  exc_d   = ovf;
                  rdy_d   = 1'b1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State registers with asynchronous clear; reset drops any in-flight operation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         p_q     <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         p_q     <= p_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: stimulus pushes expected products computed
// with 64-bit signed arithmetic; a negedge monitor pops on every ready pulse.
module tb_booth_mult;

   localparam int W = 32;
   localparam int N = W / 2;

   logic          clock;
   logic          reset;
   logic [W-1:0]  data_operandA;
   logic [W-1:0]  data_operandB;
   logic          ctrl_MULT;
   logic [W-1:0]  data_result;
   logic          data_exception;
   logic          data_resultRDY;

   booth_mult #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         exc;
      int           due;
   } exp_t;

   exp_t sbq[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && data_resultRDY) begin
         if (sbq.size() == 0) begin
            total++;
            $display("FAIL spurious_rdy: got rdy=1 result=%0h expected no pulse", data_result);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("result", data_result, e.res);
            check("exception", data_exception, e.exc);
            check("latency", cyc, e.due);
         end
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint p;
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = 1'b1;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      // A restart abandons the operation still in flight.
      if (sbq.size() != 0) void'(sbq.pop_back());
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[W-1:0];
      e.exc = (p != longint'($signed(p[W-1:0])));
      e.due = cyc + N;
      sbq.push_back(e);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (sbq.size() != 0 && i < 4 * N) begin
         @(posedge clock);
         i++;
      end
      if (sbq.size() != 0) begin
         total++;
         $display("FAIL timeout: got %0d results outstanding, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   logic [W-1:0] corners [6];

   initial begin
      logic [W-1:0] a, b;
      corners = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                  32'h0000_0001, 32'h7FFF_FFFF, 32'h4000_0000};
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (2) @(negedge clock);
      check("reset_result", data_result, 0);
      check("reset_exc", data_exception, 0);
      check("reset_rdy", data_resultRDY, 0);
      reset = 1'b0;

      // Directed products, including the overflow corners.
      start_op(32'd7, 32'd6);                   wait_idle();
      start_op(32'hFFFF_FFFD, 32'd5);           wait_idle();
      start_op(32'h8000_0000, 32'd1);           wait_idle();
      start_op(32'h8000_0000, 32'd0);           wait_idle();
      start_op(32'h4000_0000, 32'd4);           wait_idle();
      start_op(32'h8000_0000, 32'hFFFF_FFFF);   wait_idle();
      start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);   wait_idle();

      // Restart mid-operation: only the second result may appear.
      start_op(32'd7, 32'd6);
      repeat (7) @(posedge clock);
      start_op(32'hFFFF_FFFE, 32'd9);
      wait_idle();
      check("held_result", data_result, 32'hFFFF_FFEE);

      // Asynchronous reset mid-operation clears outputs at once and drops the op.
      start_op(32'd3, 32'd3);
      repeat (4) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async_result", data_result, 0);
      check("async_exc", data_exception, 0);
      check("async_rdy", data_resultRDY, 0);
      sbq.delete();
      @(negedge clock);
      reset = 1'b0;
      repeat (2 * N) @(posedge clock);
      start_op(32'd3, 32'd3);
      wait_idle();

      // Randomized operands with occasional restarts and corner values.
      for (int k = 0; k < 1000; k++) begin
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 7) == 0) a = corners[$urandom_range(0, 5)];
         if ($urandom_range(0, 7) == 0) b = corners[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) begin
            a = {{16{a[15]}}, a[15:0]};
            b = {{16{b[15]}}, b[15:0]};
         end
         start_op(a, b);
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, N - 1)) @(posedge clock);
            start_op($urandom(), $urandom());
         end
         wait_idle();
      end

      repeat (4) @(posedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
